// File: rtl/ins_execute.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Define MUL_EN to build the iterative shift-add multiplier (ALU code 1100) that stalls the front-end.
`timescale 1ns/1ps
module ins_execute #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid_in,
    input  logic [XLEN-1:0] id_pc_plus_4_in,
    input  logic [XLEN-1:0] id_read_data1_in,
    input  logic [XLEN-1:0] id_read_data2_in,
    input  logic [XLEN-1:0] id_immediate_in,
    input  logic [4:0]      id_rs1_addr_in,
    input  logic [4:0]      id_rs2_addr_in,
    input  logic [4:0]      id_rd_addr_in,
    input  logic            id_mem_read_in,
    input  logic            id_mem_write_in,
    input  logic            id_reg_write_in,
    input  logic            id_mem_to_reg_in,
    input  logic            id_alu_src_in,
    input  logic            id_branch_in,
    input  logic [2:0]      id_funct3_in,
    input  logic [3:0]      id_alu_ctrl_in,
    input  logic [4:0]      wb_write_addr_in,
    input  logic [XLEN-1:0] wb_write_data_in,
    input  logic            wb_reg_write_en_in,
    output logic            ex_stall_out,
    output logic            branch_taken_out,
    output logic [XLEN-1:0] branch_target_out,
    output logic            mem_valid_out,
    output logic [XLEN-1:0] mem_alu_result_out,
    output logic [XLEN-1:0] mem_store_data_out,
    output logic [4:0]      mem_rd_addr_out,
    output logic            mem_mem_read_out,
    output logic            mem_mem_write_out,
    output logic            mem_reg_write_out,
    output logic            mem_mem_to_reg_out,
    output logic [2:0]      mem_funct3_out
);

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLL = 4'b0101,
                           ALU_SRL = 4'b0110, ALU_SRA = 4'b0111, ALU_SLT = 4'b1000,
                           ALU_SLTU = 4'b1001, ALU_LUI = 4'b1010, ALU_MUL = 4'b1100;

    if (XLEN != 32 || MUL_BITS != XLEN) begin : g_cfg_check
        $error("ins_execute supports only XLEN = MUL_BITS = 32");
    end

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0] rs, input logic [XLEN-1:0] rf_val,
        input logic mem_ok, input logic [4:0] mem_rd, input logic [XLEN-1:0] mem_val,
        input logic wb_ok, input logic [4:0] wb_rd, input logic [XLEN-1:0] wb_val);
        if (rs != 5'd0 && mem_ok && mem_rd == rs)
            fwd_sel = mem_val;
        else if (rs != 5'd0 && wb_ok && wb_rd == rs)
            fwd_sel = wb_val;
        else
            fwd_sel = rf_val;
    endfunction

    function automatic logic [XLEN-1:0] alu_op(
        input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            ALU_ADD:  alu_op = a + b;
            ALU_SUB:  alu_op = a - b;
            ALU_AND:  alu_op = a & b;
            ALU_OR:   alu_op = a | b;
            ALU_XOR:  alu_op = a ^ b;
            ALU_SLL:  alu_op = a << sh;
            ALU_SRL:  alu_op = a >> sh;
            ALU_SRA:  alu_op = $signed(a) >>> sh;
            ALU_SLT:  alu_op = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: alu_op = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_LUI:  alu_op = b;
            default:  alu_op = '0;
        endcase
    endfunction

    function automatic logic br_cond(
        input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (f3)
            3'b000:  br_cond = (a == b);
            3'b001:  br_cond = (a != b);
            3'b100:  br_cond = ($signed(a) < $signed(b));
            3'b101:  br_cond = ($signed(a) >= $signed(b));
            3'b110:  br_cond = (a < b);
            3'b111:  br_cond = (a >= b);
            default: br_cond = 1'b0;
        endcase
    endfunction

    logic            mem_fwd_ok;
    logic [XLEN-1:0] rs1_val_p0, rs2_val_p0, op_b_p0, alu_res_p0, ex_res_p0;
    logic            cap_p0;

    // Loads are not forwarded from EX/MEM: their data does not exist until the memory stage.
    assign mem_fwd_ok = mem_valid_out && mem_reg_write_out && !mem_mem_read_out;
    assign rs1_val_p0 = fwd_sel(id_rs1_addr_in, id_read_data1_in, mem_fwd_ok, mem_rd_addr_out,
                                mem_alu_result_out, wb_reg_write_en_in, wb_write_addr_in, wb_write_data_in);
    assign rs2_val_p0 = fwd_sel(id_rs2_addr_in, id_read_data2_in, mem_fwd_ok, mem_rd_addr_out,
                                mem_alu_result_out, wb_reg_write_en_in, wb_write_addr_in, wb_write_data_in);
    assign op_b_p0    = id_alu_src_in ? id_immediate_in : rs2_val_p0;
    assign alu_res_p0 = alu_op(id_alu_ctrl_in, rs1_val_p0, op_b_p0);

`ifdef MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;
    localparam int CNT_W = $clog2(MUL_BITS + 1);

    mul_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] mcand, mplier, acc;
    logic            is_mul, mul_start, stall_raw;

    assign is_mul = id_valid_in && (id_alu_ctrl_in == ALU_MUL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (is_mul) state_nxt = S_BUSY;
            S_BUSY:  if (cnt == CNT_W'(MUL_BITS - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mul_start = (state == S_IDLE) && is_mul;
        stall_raw = mul_start || (state == S_BUSY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                cnt <= '0;
        else if (mul_start)      cnt <= '0;
        else if (state == S_BUSY) cnt <= cnt + 1'b1;
    end

    // One multiplier bit per cycle; only the low XLEN bits of the product are kept.
    always_ff @(posedge clk) begin
        if (mul_start) begin
            mcand  <= rs1_val_p0;
            mplier <= op_b_p0;
            acc    <= '0;
        end else if (state == S_BUSY) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign ex_stall_out = rst && stall_raw;
    assign ex_res_p0    = (state == S_DONE) ? acc : alu_res_p0;
`else
    assign ex_stall_out = 1'b0;
    assign ex_res_p0    = alu_res_p0;
`endif

    assign branch_taken_out  = rst && id_valid_in && id_branch_in && !ex_stall_out
                               && br_cond(id_funct3_in, rs1_val_p0, rs2_val_p0);
    assign branch_target_out = id_pc_plus_4_in - XLEN'(4) + id_immediate_in;

    // ---- EX / MEM boundary
    assign cap_p0 = id_valid_in && !ex_stall_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid_out      <= 1'b0;
            mem_alu_result_out <= '0;
            mem_store_data_out <= '0;
            mem_rd_addr_out    <= '0;
            mem_mem_read_out   <= 1'b0;
            mem_mem_write_out  <= 1'b0;
            mem_reg_write_out  <= 1'b0;
            mem_mem_to_reg_out <= 1'b0;
            mem_funct3_out     <= '0;
        end else begin
            mem_valid_out      <= cap_p0;
            mem_mem_read_out   <= cap_p0 && id_mem_read_in;
            mem_mem_write_out  <= cap_p0 && id_mem_write_in;
            mem_reg_write_out  <= cap_p0 && id_reg_write_in;
            mem_mem_to_reg_out <= cap_p0 && id_mem_to_reg_in;
            mem_alu_result_out <= ex_res_p0;
            mem_store_data_out <= rs2_val_p0;
            mem_rd_addr_out    <= id_rd_addr_in;
            mem_funct3_out     <= id_funct3_in;
        end
    end

endmodule
